vdp_host_master: RTL and testbench
==================================

VDP_HOST_MASTER -- requirements
Module: vdp_host_master

Interface
REQ-001 Parameter STROBE_CYCLES, default 4: csw_n/csr_n low width in clocks, legal range 1..15.
REQ-002 Parameter RECOVERY_CYCLES, default 8: idle gap after each access, legal range 0..15.
REQ-003 clk_logic_i  in  1  sole clock; all logic rises on this edge.
REQ-004 reset_i  in  1  synchronous, active-high reset.
REQ-005 req_valid_i  in  1  access request.
REQ-006 req_ready_o  out  1  request accepted when high together with req_valid_i.
REQ-007 req_write_i  in  1  1 = write (csw), 0 = read (csr).
REQ-008 req_mode_i  in  1  9918A MODE: 0 = VRAM data port, 1 = register/status port.
REQ-009 req_data_i  in  8  write data.
REQ-010 rsp_valid_o  out  1  one-cycle completion pulse for reads and writes.
REQ-011 rsp_data_o  out  8  last read byte.
REQ-012 mode_o  out  1  to VDP mode_i.
REQ-013 csw_n_o  out  1  to VDP csw_n_i, active low.
REQ-014 csr_n_o  out  1  to VDP csr_n_i, active low.
REQ-015 cd_o  out  8  write data to VDP cd_i.
REQ-016 cd_oe_o  out  1  cd_o drive enable.
REQ-017 cd_i  in  8  read data from VDP cd_o.
REQ-018 int_n_i  in  1  VDP int_n_o, asynchronous to this block.
REQ-019 irq_o  out  1  synchronized interrupt level, active high.
REQ-020 irq_rise_o  out  1  one-cycle pulse on irq_o rising.
REQ-021 busy_o  out  1  high whenever state is not IDLE.

Function
REQ-022 FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER.
REQ-023 IDLE: req_ready_o=1; on req_valid_i, latch write/mode/data and go to SETUP.
REQ-024 req_ready_o SHALL be 0 in every state other than IDLE; no request queuing.
REQ-025 SETUP lasts 1 cycle: mode_o and cd_o driven from the latch, cd_oe_o=1 for writes, both strobes high.
REQ-026 STROBE lasts exactly STROBE_CYCLES cycles: csw_n_o (write) or csr_n_o (read) low; the other strobe stays high.
REQ-027 Reads: cd_i SHALL be registered into rsp_data_o on the last STROBE cycle edge.
REQ-028 HOLD lasts 1 cycle: strobes high, mode_o/cd_o/cd_oe_o unchanged, rsp_valid_o=1.
REQ-029 RECOVER lasts RECOVERY_CYCLES cycles, cd_oe_o=0; skipped (HOLD to IDLE) when RECOVERY_CYCLES=0.
REQ-030 Accept-to-next-ready spacing SHALL be 2+STROBE_CYCLES+RECOVERY_CYCLES cycles.
REQ-031 Writes SHALL leave rsp_data_o unchanged.
REQ-032 csw_n_o and csr_n_o SHALL never be low in the same cycle.
REQ-033 One down-counter, width 4, shared by STROBE and RECOVER, loaded on state entry; no wrap beyond zero.
REQ-034 int_n_i passes through a 2-flop synchronizer; irq_o = inverted second flop.
REQ-035 irq_rise_o = irq_o high and previous irq_o low; independent of the access FSM.
REQ-036 A request arriving while busy is held off by req_ready_o=0; the requester keeps req_valid_i high.

Reset
REQ-037 On reset_i, state = IDLE, counter = 0, synchronizer flops = 1 (irq inactive) on the next edge, aborting any in-flight access.
REQ-038 Reset values: req_ready_o=0 during reset, then 1; rsp_valid_o=0; rsp_data_o=0x00; mode_o=0; csw_n_o=1; csr_n_o=1; cd_o=0x00; cd_oe_o=0; irq_o=0; irq_rise_o=0; busy_o=0.
REQ-039 Reset during STROBE SHALL raise the strobe on the next edge with no rsp_valid_o pulse.

Structure
REQ-040 Shared package vdp_pkg holds the FSM state enum and the MODE_DATA=0 / MODE_REG=1 constants.
REQ-041 Sub-module sync_2ff (2-flop synchronizer, parameter reset value) instantiated for int_n_i.

Verification
REQ-042 Write mode=1, data 0x81, S=4, R=8: csw_n_o low exactly 4 cycles; cd_o=0x81 and cd_oe_o=1 from SETUP through HOLD; ready returns 14 cycles after accept.
REQ-043 Read mode=0, VDP model drives 0x5A on cd_i during strobe: csr_n_o low 4 cycles; rsp_valid_o pulses once in HOLD with rsp_data_o=0x5A.
REQ-044 Back-to-back reads with req_valid_i held high: second accept exactly 14 cycles after the first; strobes never overlap.
REQ-045 R=0, S=1: accept-to-ready spacing of 3 cycles; no RECOVER cycle appears.
REQ-046 reset_i asserted on the 2nd STROBE cycle of a write: csw_n_o=1 on next edge; no rsp_valid_o; req_ready_o=1 after reset release.
REQ-047 int_n_i falls asynchronously: irq_o rises within 2-3 cycles; irq_rise_o pulses exactly once; int_n_i rising clears irq_o with no pulse.

Source files
------------

// File: rtl/vdp_pkg.sv
// Shared types and constants for the TMS9918A-style VDP host-side access master.
package vdp_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 8;

  localparam logic MODE_DATA = 1'b0;
  localparam logic MODE_REG  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } state_e;

  // Access captured at accept time and held for the whole bus cycle.
  typedef struct packed {
    logic              write;
    logic              mode;
    logic [DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; reset value is a parameter.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d_i;
    s2_d = s1_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/vdp_host_master.sv
// Host-side bus master driving the VDP csw_n/csr_n/mode/cd pins with fixed strobe and recovery timing.
module vdp_host_master
  import vdp_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES   = 4,
  parameter int unsigned RECOVERY_CYCLES = 8
) (
  input  logic              clk_logic_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic              req_mode_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              mode_o,
  output logic              csw_n_o,
  output logic              csr_n_o,
  output logic [DATA_W-1:0] cd_o,
  output logic              cd_oe_o,
  input  logic [DATA_W-1:0] cd_i,
  input  logic              int_n_i,
  output logic              irq_o,
  output logic              irq_rise_o,
  output logic              busy_o
);

  localparam logic [CNT_W-1:0] STROBE_LOAD  = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECOVER_LOAD =
    (RECOVERY_CYCLES == 0) ? '0 : CNT_W'(RECOVERY_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic              accept;

  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              csw_n_q, csw_n_d;
  logic              csr_n_q, csr_n_d;
  logic              cd_oe_q, cd_oe_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              irq_prev_q, irq_prev_d;
  logic              int_n_sync;

  assign accept = (state_q == ST_IDLE) && ready_q && req_valid_i;

  // State, shared down-counter and request latch.
  always_ff @(posedge clk_logic_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Next state; the counter is loaded on entry to STROBE/RECOVER and stops at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_SETUP;
          req_d.write = req_write_i;
          req_d.mode  = req_mode_i;
          req_d.data  = req_data_i;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = STROBE_LOAD;
      end
      ST_STROBE: begin
        if (cnt_q == '0) state_d = ST_HOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_HOLD: begin
        if (RECOVERY_CYCLES == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RECOVER;
          cnt_d   = RECOVER_LOAD;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every pin comes straight off a flop.
  always_comb begin
    ready_d     = 1'b0;
    busy_d      = 1'b1;
    csw_n_d     = 1'b1;
    csr_n_d     = 1'b1;
    cd_oe_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    irq_prev_d  = irq_o;
    unique case (state_d)
      ST_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      ST_SETUP: cd_oe_d = req_d.write;
      ST_STROBE: begin
        cd_oe_d = req_d.write;
        csw_n_d = ~req_d.write;
        csr_n_d = req_d.write;
      end
      ST_HOLD: begin
        cd_oe_d     = req_d.write;
        rsp_valid_d = 1'b1;
      end
      ST_RECOVER: cd_oe_d = 1'b0;
      default: busy_d = 1'b0;
    endcase
    if ((state_q == ST_STROBE) && (cnt_q == '0) && !req_q.write) begin
      rsp_data_d = cd_i;
    end
  end

  always_ff @(posedge clk_logic_i) begin
    if (reset_i) begin
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      csw_n_q     <= 1'b1;
      csr_n_q     <= 1'b1;
      cd_oe_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      irq_prev_q  <= 1'b0;
    end else begin
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      csw_n_q     <= csw_n_d;
      csr_n_q     <= csr_n_d;
      cd_oe_q     <= cd_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      irq_prev_q  <= irq_prev_d;
    end
  end

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_int_sync (
    .clk_i   (clk_logic_i),
    .reset_i (reset_i),
    .d_i     (int_n_i),
    .q_o     (int_n_sync)
  );

  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign csw_n_o     = csw_n_q;
  assign csr_n_o     = csr_n_q;
  assign cd_oe_o     = cd_oe_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign mode_o      = req_q.mode;
  assign cd_o        = req_q.data;
  assign irq_o       = ~int_n_sync;
  assign irq_rise_o  = irq_o & ~irq_prev_q;

endmodule

// File: tb/tb_vdp_host_master.sv
// Directed bench for vdp_host_master: default-timing and S=1/R=0 instances, table-driven accesses.
module tb_vdp_host_master;
  import vdp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       req_valid, req_write, req_mode;
  logic [7:0] req_data;
  logic       sel;
  logic       int_n;
  logic [7:0] vdp_byte;

  logic       m_ready, m_rv, m_mode, m_csw, m_csr, m_oe, m_irq, m_rise, m_busy;
  logic [7:0] m_rsp, m_cd, m_cd_i;
  logic       f_ready, f_rv, f_mode, f_csw, f_csr, f_oe, f_irq, f_rise, f_busy;
  logic [7:0] f_rsp, f_cd, f_cd_i;

  // VDP model: drives its byte only while the read strobe is low.
  assign m_cd_i = m_csr ? 8'hFF : vdp_byte;
  assign f_cd_i = f_csr ? 8'hFF : vdp_byte;

  vdp_host_master #(.STROBE_CYCLES(4), .RECOVERY_CYCLES(8)) dut (
    .clk_logic_i(clk), .reset_i(reset),
    .req_valid_i(req_valid & ~sel), .req_ready_o(m_ready),
    .req_write_i(req_write), .req_mode_i(req_mode), .req_data_i(req_data),
    .rsp_valid_o(m_rv), .rsp_data_o(m_rsp), .mode_o(m_mode),
    .csw_n_o(m_csw), .csr_n_o(m_csr), .cd_o(m_cd), .cd_oe_o(m_oe), .cd_i(m_cd_i),
    .int_n_i(int_n), .irq_o(m_irq), .irq_rise_o(m_rise), .busy_o(m_busy)
  );

  vdp_host_master #(.STROBE_CYCLES(1), .RECOVERY_CYCLES(0)) dut_fast (
    .clk_logic_i(clk), .reset_i(reset),
    .req_valid_i(req_valid & sel), .req_ready_o(f_ready),
    .req_write_i(req_write), .req_mode_i(req_mode), .req_data_i(req_data),
    .rsp_valid_o(f_rv), .rsp_data_o(f_rsp), .mode_o(f_mode),
    .csw_n_o(f_csw), .csr_n_o(f_csr), .cd_o(f_cd), .cd_oe_o(f_oe), .cd_i(f_cd_i),
    .int_n_i(1'b1), .irq_o(f_irq), .irq_rise_o(f_rise), .busy_o(f_busy)
  );

  logic       mon_ready, mon_rv, mon_mode, mon_csw, mon_csr, mon_oe, mon_busy;
  logic [7:0] mon_rsp, mon_cd;
  assign mon_ready = sel ? f_ready : m_ready;
  assign mon_rv    = sel ? f_rv    : m_rv;
  assign mon_mode  = sel ? f_mode  : m_mode;
  assign mon_csw   = sel ? f_csw   : m_csw;
  assign mon_csr   = sel ? f_csr   : m_csr;
  assign mon_oe    = sel ? f_oe    : m_oe;
  assign mon_busy  = sel ? f_busy  : m_busy;
  assign mon_rsp   = sel ? f_rsp   : m_rsp;
  assign mon_cd    = sel ? f_cd    : m_cd;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // One access from the negedge where the request is presented until ready returns.
  task automatic run_txn(input bit s, input bit w, input bit m, input logic [7:0] d,
                         input logic [7:0] vb, input logic [7:0] exp_rsp,
                         input bit hold_valid, output int wait_cnt);
    int scyc, rcyc;
    int ready_low, csw_low, csr_low, overlap, oe_cnt, cd_ok, mode_ok, rv_cnt, busy_bad, rsp_at;
    scyc = s ? 1 : 4;
    rcyc = s ? 0 : 8;
    sel = s; vdp_byte = vb; req_write = w; req_mode = m; req_data = d; req_valid = 1'b1;
    wait_cnt = 0;
    while (!mon_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (wait_cnt >= 50) begin
      check("accept_timeout", wait_cnt, 0);
      req_valid = 1'b0;
      return;
    end
    ready_low = 0; csw_low = 0; csr_low = 0; overlap = 0; oe_cnt = 0;
    cd_ok = 0; mode_ok = 0; rv_cnt = 0; busy_bad = 0; rsp_at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0 && !hold_valid) req_valid = 1'b0;
      if (mon_ready) break;
      ready_low++;
      if (!mon_csw) csw_low++;
      if (!mon_csr) csr_low++;
      if (!mon_csw && !mon_csr) overlap++;
      if (mon_oe) begin
        oe_cnt++;
        if (mon_cd == d) cd_ok++;
      end
      if (mon_mode == m) mode_ok++;
      if (!mon_busy) busy_bad++;
      if (mon_rv) begin
        rv_cnt++;
        rsp_at = int'(mon_rsp);
      end
    end
    check("ready_low_cycles", ready_low, 2 + scyc + rcyc);
    check("csw_low_cycles", csw_low, w ? scyc : 0);
    check("csr_low_cycles", csr_low, w ? 0 : scyc);
    check("strobe_overlap", overlap, 0);
    check("cd_oe_cycles", oe_cnt, w ? scyc + 2 : 0);
    check("cd_o_value_cycles", cd_ok, w ? scyc + 2 : 0);
    check("mode_o_cycles", mode_ok, 2 + scyc + rcyc);
    check("busy_cycles_bad", busy_bad, 0);
    check("rsp_valid_pulses", rv_cnt, 1);
    check("rsp_data_at_valid", rsp_at, int'(exp_rsp));
    check("rsp_data_after", int'(mon_rsp), int'(exp_rsp));
  endtask

  typedef struct {
    bit         sel;
    bit         write;
    bit         mode;
    logic [7:0] data;
    logic [7:0] vdp;
    logic [7:0] exp_rsp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int w0, rv_seen, cyc;
    vecs[0] = '{0, 0, MODE_DATA, 8'h00, 8'h5A, 8'h5A};
    vecs[1] = '{0, 1, MODE_REG,  8'h81, 8'hEE, 8'h5A};
    vecs[2] = '{0, 0, MODE_REG,  8'h00, 8'hC3, 8'hC3};
    vecs[3] = '{0, 1, MODE_DATA, 8'h00, 8'h77, 8'hC3};
    vecs[4] = '{0, 0, MODE_DATA, 8'h00, 8'h00, 8'h00};
    vecs[5] = '{0, 1, MODE_REG,  8'hFF, 8'h11, 8'h00};
    vecs[6] = '{1, 0, MODE_REG,  8'h00, 8'hA5, 8'hA5};
    vecs[7] = '{1, 1, MODE_DATA, 8'h3C, 8'h99, 8'hA5};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_mode = 1'b0;
    req_data = 8'h00; sel = 1'b0; int_n = 1'b1; vdp_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", m_ready, 0);
    check("rst_rsp_valid", m_rv, 0);
    check("rst_rsp_data", m_rsp, 0);
    check("rst_mode", m_mode, 0);
    check("rst_csw_n", m_csw, 1);
    check("rst_csr_n", m_csr, 1);
    check("rst_cd", m_cd, 0);
    check("rst_cd_oe", m_oe, 0);
    check("rst_irq", m_irq, 0);
    check("rst_irq_rise", m_rise, 0);
    check("rst_busy", m_busy, 0);
    check("rst_fast_ready", f_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", m_ready, 1);
    check("post_rst_fast_ready", f_ready, 1);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].sel, vecs[i].write, vecs[i].mode, vecs[i].data,
              vecs[i].vdp, vecs[i].exp_rsp, 1'b0, w0);
    end

    // Back-to-back reads with valid held: second accept lands on the first ready cycle.
    run_txn(1'b0, 1'b0, MODE_DATA, 8'h00, 8'h11, 8'h11, 1'b1, w0);
    run_txn(1'b0, 1'b0, MODE_REG,  8'h00, 8'h22, 8'h22, 1'b0, w0);
    check("b2b_second_accept_wait", w0, 0);

    // Reset during the second STROBE cycle of a write aborts it without a response.
    sel = 1'b0; req_write = 1'b1; req_mode = MODE_REG; req_data = 8'h42; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_csw_low_before", m_csw, 0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_csw_high", m_csw, 1);
    check("abort_rsp_valid", m_rv, 0);
    check("abort_busy", m_busy, 0);
    check("abort_ready_in_reset", m_ready, 0);
    check("abort_rsp_data", m_rsp, 0);
    reset = 1'b0;
    rv_seen = 0;
    @(negedge clk);
    check("abort_ready_after", m_ready, 1);
    repeat (4) begin
      @(negedge clk);
      if (m_rv) rv_seen++;
    end
    check("abort_no_rsp_valid", rv_seen, 0);

    // Asynchronous interrupt assertion and release.
    @(posedge clk);
    #3 int_n = 1'b0;
    cyc = 0;
    rv_seen = 0;
    while (cyc < 6) begin
      @(posedge clk);
      #1;
      cyc++;
      if (m_rise) rv_seen++;
      if (m_irq) break;
    end
    check_range("irq_latency", cyc, 2, 3);
    repeat (6) begin
      @(posedge clk);
      #1;
      if (m_rise) rv_seen++;
    end
    check("irq_level_held", m_irq, 1);
    check("irq_rise_pulses", rv_seen, 1);
    #2 int_n = 1'b1;
    rv_seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (m_rise) rv_seen++;
    end
    check("irq_cleared", m_irq, 0);
    check("irq_no_rise_on_release", rv_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
